// File: rtl/button_event_encoder_if.sv
// Press-event handshake between the button encoder and its consumer.
// The encoder drives a 3-bit button ID with a valid flag; the consumer
// answers with ready. IDs 1..4 name b1..b4, 0 means no entry.
interface button_event_encoder_if;
  logic       press_valid;
  logic [2:0] press_id;
  logic       press_ready;

  modport master (
    output press_valid,
    output press_id,
    input  press_ready
  );

  modport slave (
    input  press_valid,
    input  press_id,
    output press_ready
  );
endinterface

// File: rtl/button_event_encoder.sv
// Button event encoder: synchronizes and debounces four raw push-buttons,
// turns debounced rising edges into pending presses (one slot per button)
// and hands them out one at a time, lowest button first, over a
// valid/ready handshake. Presses that arrive while a button's slot is
// still occupied are lost and tallied in a saturating drop counter.
module button_event_encoder #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    b1,
  input  logic                    b2,
  input  logic                    b3,
  input  logic                    b4,
  button_event_encoder_if.master  press,
  output logic [3:0]              btn_level,
  output logic [7:0]              drop_count
);

  // Counter value on which a level change is finally accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       w_raw;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [CNT_W-1:0] r_count [4];
  logic [3:0]       r_level;
  logic [3:0]       w_toggle;
  logic [3:0]       w_pressEdge;
  logic [3:0]       r_pending;
  logic [3:0]       w_grant;
  logic [2:0]       w_grantId;
  logic             w_anyPending;
  logic             w_load;
  logic [3:0]       w_clear;
  logic [3:0]       w_dropVec;
  logic [2:0]       w_dropNum;
  logic [8:0]       w_dropSum;
  logic             r_valid;
  logic [2:0]       r_id;
  logic [7:0]       r_drop;

  assign w_raw = {b4, b3, b2, b1};

  // Two-flop synchronizer per button; only the second stage is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A level change is accepted on the edge its counter has already seen
  // DEBOUNCE_CYCLES-1 consecutive disagreeing samples plus this one.
  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < 4; i++) begin
      w_toggle[i] = (r_sync2[i] != r_level[i]) && (r_count[i] == CNT_MAX);
    end
  end

  // Only 0->1 transitions of the debounced level are presses.
  assign w_pressEdge = w_toggle & ~r_level;

  // Per-button debounce counter and debounced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
      for (int i = 0; i < 4; i++) begin
        r_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_count[i] <= '0;
        end else if (w_toggle[i]) begin
          r_level[i] <= ~r_level[i];
          r_count[i] <= '0;
        end else begin
          r_count[i] <= r_count[i] + CNT_W'(1);
        end
      end
    end
  end

  assign btn_level = r_level;

  // Output register accepts a new entry when empty or when the current
  // entry is being taken by the consumer this cycle.
  assign w_load = ~r_valid | press.press_ready;

  // Fixed priority select over the pending slots, b1 first.
  always_comb begin
    w_grant      = '0;
    w_grantId    = '0;
    w_anyPending = 1'b0;
    if (r_pending[0]) begin
      w_grant      = 4'b0001;
      w_grantId    = 3'd1;
      w_anyPending = 1'b1;
    end else if (r_pending[1]) begin
      w_grant      = 4'b0010;
      w_grantId    = 3'd2;
      w_anyPending = 1'b1;
    end else if (r_pending[2]) begin
      w_grant      = 4'b0100;
      w_grantId    = 3'd3;
      w_anyPending = 1'b1;
    end else if (r_pending[3]) begin
      w_grant      = 4'b1000;
      w_grantId    = 3'd4;
      w_anyPending = 1'b1;
    end
  end

  assign w_clear = w_load ? w_grant : 4'b0000;

  // A press is lost only when its slot is full and not draining this edge;
  // if the slot drains on the same edge the new press simply refills it.
  assign w_dropVec = w_pressEdge & r_pending & ~w_clear;
  assign w_dropNum = {2'b00, w_dropVec[0]} + {2'b00, w_dropVec[1]}
                   + {2'b00, w_dropVec[2]} + {2'b00, w_dropVec[3]};
  assign w_dropSum = {1'b0, r_drop} + {6'b000000, w_dropNum};

  // Pending slots: set on a press edge, cleared when loaded into the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clear) | w_pressEdge;
    end
  end

  // Single-entry output register holding the event offered to the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_id    <= '0;
    end else if (w_load) begin
      r_valid <= w_anyPending;
      r_id    <= w_grantId;
    end
  end

  assign press.press_valid = r_valid;
  assign press.press_id    = r_id;

  // Saturating tally of lost presses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_dropSum[8]) begin
      r_drop <= 8'hFF;
    end else begin
      r_drop <= w_dropSum[7:0];
    end
  end

  assign drop_count = r_drop;

endmodule

// File: tb/tb_button_event_encoder.sv
// Directed bench for button_event_encoder with a short debounce window.
// Inputs change 1 time unit after a rising clock edge and outputs are
// sampled at the same point, so each step observes the state left by the
// edge just taken.
module tb_button_event_encoder;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       b1, b2, b3, b4;
  logic [3:0] btnLevel;
  logic [7:0] dropCount;

  int         checkCount  = 0;
  int         errorCount  = 0;
  int         eventCount;
  logic [2:0] lastId;

  button_event_encoder_if ifc ();

  button_event_encoder #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .b1         (b1),
    .b2         (b2),
    .b3         (b3),
    .b4         (b4),
    .press      (ifc.master),
    .btn_level  (btnLevel),
    .drop_count (dropCount)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive buttons {b4,b3,b2,b1} and ready, then run the given edges.
  task automatic applyStimulus(input logic [3:0] buttons, input logic ready, input int cycles);
    {b4, b3, b2, b1}  = buttons;
    ifc.press_ready   = ready;
    for (int c = 0; c < cycles; c++) begin
      tick();
    end
  endtask

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Like applyStimulus, but records every cycle the output holds an event.
  task automatic countEvents(input logic [3:0] buttons, input int cycles);
    {b4, b3, b2, b1} = buttons;
    ifc.press_ready  = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (ifc.press_valid) begin
        eventCount++;
        lastId = ifc.press_id;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    {b4, b3, b2, b1} = 4'b0000;
    ifc.press_ready  = 1'b1;
    tick();
    tick();
    checkOutput("reset_valid", {7'd0, ifc.press_valid}, 8'd0);
    checkOutput("reset_id",    {5'd0, ifc.press_id},    8'd0);
    checkOutput("reset_level", {4'd0, btnLevel},        8'd0);
    checkOutput("reset_drop",  dropCount,               8'd0);
    rst = 1'b0;
    applyStimulus(4'b0000, 1'b1, 3);

    // Clean b2 press: level after edge 5, one-cycle event after edge 6.
    applyStimulus(4'b0010, 1'b1, 5);
    checkOutput("clean_level_e4", {4'd0, btnLevel},        8'd0);
    checkOutput("clean_valid_e4", {7'd0, ifc.press_valid}, 8'd0);
    applyStimulus(4'b0010, 1'b1, 1);
    checkOutput("clean_level_e5", {4'd0, btnLevel},        8'd2);
    checkOutput("clean_valid_e5", {7'd0, ifc.press_valid}, 8'd0);
    applyStimulus(4'b0010, 1'b1, 1);
    checkOutput("clean_valid_e6", {7'd0, ifc.press_valid}, 8'd1);
    checkOutput("clean_id_e6",    {5'd0, ifc.press_id},    8'd2);
    applyStimulus(4'b0010, 1'b1, 1);
    checkOutput("clean_valid_e7", {7'd0, ifc.press_valid}, 8'd0);
    checkOutput("clean_id_e7",    {5'd0, ifc.press_id},    8'd0);
    applyStimulus(4'b0000, 1'b1, 8);
    checkOutput("release_level",  {4'd0, btnLevel},        8'd0);

    // Bouncing b1: no event while toggling every 2 cycles, then one event.
    eventCount = 0;
    lastId     = 3'd0;
    for (int c = 0; c < 12; c++) begin
      countEvents(((c / 2) % 2 == 0) ? 4'b0001 : 4'b0000, 1);
    end
    checkOutput("bounce_events", eventCount[7:0], 8'd0);
    countEvents(4'b0001, 12);
    checkOutput("bounce_hold_events", eventCount[7:0], 8'd1);
    checkOutput("bounce_hold_id",     {5'd0, lastId},  8'd1);
    eventCount = 0;
    countEvents(4'b0000, 10);
    checkOutput("bounce_release_events", eventCount[7:0], 8'd0);

    // Priority and backpressure: b1 and b3 debounce together, ready low.
    applyStimulus(4'b0101, 1'b0, 7);
    checkOutput("prio_valid_0", {7'd0, ifc.press_valid}, 8'd1);
    checkOutput("prio_id_0",    {5'd0, ifc.press_id},    8'd1);
    checkOutput("prio_level",   {4'd0, btnLevel},        8'd5);
    for (int c = 1; c < 5; c++) begin
      applyStimulus(4'b0101, 1'b0, 1);
      checkOutput("prio_hold_valid", {7'd0, ifc.press_valid}, 8'd1);
      checkOutput("prio_hold_id",    {5'd0, ifc.press_id},    8'd1);
    end
    applyStimulus(4'b0101, 1'b1, 1);
    checkOutput("prio_second_valid", {7'd0, ifc.press_valid}, 8'd1);
    checkOutput("prio_second_id",    {5'd0, ifc.press_id},    8'd3);
    applyStimulus(4'b0101, 1'b1, 1);
    checkOutput("prio_empty_valid", {7'd0, ifc.press_valid}, 8'd0);
    checkOutput("prio_empty_id",    {5'd0, ifc.press_id},    8'd0);
    applyStimulus(4'b0000, 1'b0, 8);

    // Drop: b2 occupies output, b4 pending, second b4 press is lost.
    applyStimulus(4'b0010, 1'b0, 7);
    checkOutput("drop_first_id", {5'd0, ifc.press_id}, 8'd2);
    applyStimulus(4'b1010, 1'b0, 7);
    checkOutput("drop_pending_count", dropCount, 8'd0);
    applyStimulus(4'b0010, 1'b0, 7);
    applyStimulus(4'b1010, 1'b0, 7);
    checkOutput("drop_count_one", dropCount, 8'd1);
    checkOutput("drop_held_id",   {5'd0, ifc.press_id}, 8'd2);
    applyStimulus(4'b1010, 1'b1, 1);
    checkOutput("drop_next_valid", {7'd0, ifc.press_valid}, 8'd1);
    checkOutput("drop_next_id",    {5'd0, ifc.press_id},    8'd4);
    applyStimulus(4'b1010, 1'b1, 1);
    checkOutput("drop_drained_valid", {7'd0, ifc.press_valid}, 8'd0);
    applyStimulus(4'b0000, 1'b0, 8);

    // Saturation: b1 holds output and slot, then 259 more b1 presses drop.
    applyStimulus(4'b0001, 1'b0, 7);
    checkOutput("sat_first_id", {5'd0, ifc.press_id}, 8'd1);
    applyStimulus(4'b0000, 1'b0, 7);
    applyStimulus(4'b0001, 1'b0, 7);
    checkOutput("sat_pending_count", dropCount, 8'd1);
    applyStimulus(4'b0000, 1'b0, 7);
    for (int k = 1; k <= 259; k++) begin
      applyStimulus(4'b0001, 1'b0, 7);
      applyStimulus(4'b0000, 1'b0, 7);
      if (k == 99) begin
        checkOutput("sat_count_100", dropCount, 8'd100);
      end
    end
    checkOutput("sat_count_255", dropCount, 8'd255);
    checkOutput("sat_held_id",   {5'd0, ifc.press_id}, 8'd1);
    applyStimulus(4'b0000, 1'b1, 1);
    checkOutput("sat_next_id", {5'd0, ifc.press_id}, 8'd1);
    applyStimulus(4'b0000, 1'b1, 1);
    checkOutput("sat_drained_valid", {7'd0, ifc.press_valid}, 8'd0);
    checkOutput("sat_count_stays",   dropCount, 8'd255);

    // Mid-run reset with an event waiting: outputs clear without a clock edge.
    applyStimulus(4'b0100, 1'b0, 7);
    checkOutput("rst_pre_valid", {7'd0, ifc.press_valid}, 8'd1);
    checkOutput("rst_pre_id",    {5'd0, ifc.press_id},    8'd3);
    rst = 1'b1;
    #2;
    checkOutput("rst_async_valid", {7'd0, ifc.press_valid}, 8'd0);
    checkOutput("rst_async_id",    {5'd0, ifc.press_id},    8'd0);
    checkOutput("rst_async_level", {4'd0, btnLevel},        8'd0);
    checkOutput("rst_async_drop",  dropCount,               8'd0);
    tick();

    // b3 held across reset produces an event after the debounce delay.
    rst = 1'b0;
    applyStimulus(4'b0100, 1'b0, 6);
    checkOutput("held_valid_e5", {7'd0, ifc.press_valid}, 8'd0);
    applyStimulus(4'b0100, 1'b0, 1);
    checkOutput("held_valid_e6", {7'd0, ifc.press_valid}, 8'd1);
    checkOutput("held_id_e6",    {5'd0, ifc.press_id},    8'd3);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
